// File: rtl/arb_mux_4.sv
// Four-source round-robin arbiter feeding a single registered output slot.
// o_s names the source held in o_out, for use as a downstream 4:1 mux select.
module arb_mux_4 #(
  parameter int unsigned N = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [3:0]   i_valid,
  output logic [3:0]   o_ready,
  input  logic [N-1:0] i_in0,
  input  logic [N-1:0] i_in1,
  input  logic [N-1:0] i_in2,
  input  logic [N-1:0] i_in3,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_out,
  output logic [1:0]   o_s
);

  localparam int unsigned NSRC = 4;
  localparam int unsigned SW   = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e         state_q;
  logic [SW-1:0]  ptr_q;
  logic [SW-1:0]  s_q;
  logic [N-1:0]   out_q;

  logic           load;
  logic           found;
  logic [SW-1:0]  grant;
  logic [SW-1:0]  idx;
  logic           xfer;
  logic [N-1:0]   sel_data;

  assign load = (state_q == EMPTY) || i_ready;

  // First valid source at or after the pointer, wrapping modulo 4.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      idx = SW'(ptr_q + SW'(i));
      if (!found && i_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    o_ready = '0;
    if (!i_rst && load && found) begin
      o_ready[grant] = 1'b1;
    end
  end

  assign xfer = |o_ready;

  always_comb begin
    case (grant)
      2'd0:    sel_data = i_in0;
      2'd1:    sel_data = i_in1;
      2'd2:    sel_data = i_in2;
      default: sel_data = i_in3;
    endcase
  end

  // Output slot: fills on a transfer, drains when consumed with nothing new.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      s_q     <= '0;
      out_q   <= '0;
    end else if (load) begin
      if (xfer) begin
        state_q <= FULL;
        out_q   <= sel_data;
        s_q     <= grant;
        ptr_q   <= SW'(grant + SW'(1));
      end else begin
        state_q <= EMPTY;
      end
    end
  end

  assign o_valid = (state_q == FULL);
  assign o_out   = out_q;
  assign o_s     = s_q;

endmodule

// File: tb/tb_arb_mux_4.sv
// Directed bench for arb_mux_4: reset, single grant, rotation, backpressure,
// pointer wrap with skipping, and reset in the middle of traffic.
module tb_arb_mux_4;

  localparam int unsigned N = 64;

  logic         clk;
  logic         rst;
  logic [3:0]   valid_in;
  logic [3:0]   ready_out;
  logic [N-1:0] in0, in1, in2, in3;
  logic         valid_out;
  logic         ready_in;
  logic [N-1:0] data_out;
  logic [1:0]   s_out;

  int n_pass;
  int n_total;

  localparam logic [N-1:0] DA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [N-1:0] DB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [N-1:0] DC = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [N-1:0] DD = 64'hDDDD_DDDD_DDDD_DDDD;

  arb_mux_4 #(.N(N)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid_in),
    .o_ready (ready_out),
    .i_in0   (in0),
    .i_in1   (in1),
    .i_in2   (in2),
    .i_in3   (in3),
    .o_valid (valid_out),
    .i_ready (ready_in),
    .o_out   (data_out),
    .o_s     (s_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid_in = 4'b0000;
    ready_in = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_in = 4'b1111;
    ready_in = 1'b1;
    tick();
    tick();
    n_total++;
    if (valid_out !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_out);
    else n_pass++;
    n_total++;
    if (data_out !== '0) $display("FAIL reset_out got=%h exp=0", data_out);
    else n_pass++;
    n_total++;
    if (s_out !== 2'd0) $display("FAIL reset_s got=%0d exp=0", s_out);
    else n_pass++;
    n_total++;
    if (ready_out !== 4'b0000) $display("FAIL reset_ready got=%b exp=0000", ready_out);
    else n_pass++;
    rst = 1'b0;
    valid_in = 4'b0000;
  endtask

  task automatic test_single();
    do_reset();
    valid_in = 4'b0100;
    ready_in = 1'b1;
    #1;
    n_total++;
    if (ready_out !== 4'b0100) $display("FAIL single_ready got=%b exp=0100", ready_out);
    else n_pass++;
    tick();
    valid_in = 4'b0000;
    n_total++;
    if (valid_out !== 1'b1) $display("FAIL single_valid got=%b exp=1", valid_out);
    else n_pass++;
    n_total++;
    if (data_out !== DC) $display("FAIL single_out got=%h exp=%h", data_out, DC);
    else n_pass++;
    n_total++;
    if (s_out !== 2'd2) $display("FAIL single_s got=%0d exp=2", s_out);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0]   exp_s [5];
    logic [N-1:0] exp_d [5];
    exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_d = '{DA, DB, DC, DD, DA};
    do_reset();
    valid_in = 4'b1111;
    ready_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_total++;
      if (s_out !== exp_s[c]) $display("FAIL rr_s[%0d] got=%0d exp=%0d", c, s_out, exp_s[c]);
      else n_pass++;
      n_total++;
      if (data_out !== exp_d[c]) $display("FAIL rr_out[%0d] got=%h exp=%h", c, data_out, exp_d[c]);
      else n_pass++;
    end
    valid_in = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    valid_in = 4'b0010;
    ready_in = 1'b1;
    tick();
    valid_in = 4'b1111;
    ready_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_total++;
      if (ready_out !== 4'b0000) $display("FAIL bp_ready[%0d] got=%b exp=0000", c, ready_out);
      else n_pass++;
      tick();
      n_total++;
      if (data_out !== DB || s_out !== 2'd1 || valid_out !== 1'b1)
        $display("FAIL bp_hold[%0d] got out=%h s=%0d v=%b exp out=%h s=1 v=1",
                 c, data_out, s_out, valid_out, DB);
      else n_pass++;
    end
    ready_in = 1'b1;
    #1;
    n_total++;
    if (ready_out !== 4'b0100) $display("FAIL bp_release_ready got=%b exp=0100", ready_out);
    else n_pass++;
    tick();
    n_total++;
    if (s_out !== 2'd2) $display("FAIL bp_release_s got=%0d exp=2", s_out);
    else n_pass++;
    valid_in = 4'b0000;
  endtask

  task automatic test_wrap_skip();
    do_reset();
    valid_in = 4'b0100;
    ready_in = 1'b1;
    tick();
    valid_in = 4'b1001;
    #1;
    n_total++;
    if (ready_out !== 4'b1000) $display("FAIL wrap_ready got=%b exp=1000", ready_out);
    else n_pass++;
    tick();
    n_total++;
    if (s_out !== 2'd3 || data_out !== DD) $display("FAIL wrap_s3 got s=%0d out=%h exp s=3 out=%h", s_out, data_out, DD);
    else n_pass++;
    tick();
    n_total++;
    if (s_out !== 2'd0 || data_out !== DA) $display("FAIL wrap_s0 got s=%0d out=%h exp s=0 out=%h", s_out, data_out, DA);
    else n_pass++;
    valid_in = 4'b0000;
    #1;
    n_total++;
    if (ready_out !== 4'b0000) $display("FAIL idle_ready got=%b exp=0000", ready_out);
    else n_pass++;
    tick();
    n_total++;
    if (valid_out !== 1'b0 || data_out !== DA || s_out !== 2'd0)
      $display("FAIL drain got v=%b out=%h s=%0d exp v=0 out=%h s=0", valid_out, data_out, s_out, DA);
    else n_pass++;
    // Pointer is now 1: with sources 0 and 3 pending, 3 wins before 0.
    valid_in = 4'b1001;
    #1;
    n_total++;
    if (ready_out !== 4'b1000) $display("FAIL skip_ready got=%b exp=1000", ready_out);
    else n_pass++;
    valid_in = 4'b0000;
  endtask

  task automatic test_mid_reset();
    do_reset();
    valid_in = 4'b0100;
    ready_in = 1'b1;
    tick();
    n_total++;
    if (s_out !== 2'd2 || valid_out !== 1'b1) $display("FAIL mid_pre got s=%0d v=%b exp s=2 v=1", s_out, valid_out);
    else n_pass++;
    valid_in = 4'b1111;
    rst = 1'b1;
    #1;
    n_total++;
    if (ready_out !== 4'b0000) $display("FAIL mid_rst_ready got=%b exp=0000", ready_out);
    else n_pass++;
    tick();
    rst = 1'b0;
    n_total++;
    if (valid_out !== 1'b0 || data_out !== '0) $display("FAIL mid_rst got v=%b out=%h exp v=0 out=0", valid_out, data_out);
    else n_pass++;
    tick();
    n_total++;
    if (s_out !== 2'd0 || data_out !== DA || valid_out !== 1'b1)
      $display("FAIL mid_first got s=%0d out=%h v=%b exp s=0 out=%h v=1", s_out, data_out, valid_out, DA);
    else n_pass++;
    valid_in = 4'b0000;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    valid_in = 4'b0000;
    ready_in = 1'b0;
    in0 = DA;
    in1 = DB;
    in2 = DC;
    in3 = DD;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/arb_mux_4.md
ARB_MUX_4 -- requirements
Module: arb_mux_4

Interface
REQ-001 The block SHALL have one parameter: N, default 64, the data width of every data input and of the output.
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-003 The ports SHALL be as follows, clock and reset first:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  4  per-source valid; bit k qualifies i_in<k>.
- o_ready  output  4  per-source ready; at most one bit high.
- i_in0, i_in1, i_in2, i_in3  input  N  source data.
- o_valid  output  1  the output register holds valid data.
- i_ready  input  1  the downstream consumer accepts o_out.
- o_out  output  N  registered selected data.
- o_s  output  2  index of the source currently held in o_out; this is the select value a downstream 4:1 mux consumes.

Function
REQ-004 The block SHALL hold a 2-bit priority pointer ptr and a single output register (o_out, o_s, o_valid).
REQ-005 The load condition SHALL be load = !o_valid || i_ready.
REQ-006 When load=1 and i_valid!=0, the block SHALL grant exactly one source: the first set bit of i_valid searched in the order ptr, ptr+1, ptr+2, ptr+3, modulo 4.
REQ-007 o_ready SHALL be combinational and one-hot at the granted index when load=1 and i_valid!=0, and SHALL be 4'b0000 otherwise.
REQ-008 A transfer from source k SHALL occur in a cycle where i_valid[k]=1 and o_ready[k]=1.
REQ-009 On a transfer from source k, at the next edge: o_out<=i_in<k>, o_s<=k, o_valid<=1, and ptr<=(k+1) mod 4, with wrap 3->0.
REQ-010 When load=1 and i_valid=0, at the next edge: o_valid<=0, while o_out, o_s and ptr hold.
REQ-011 When load=0 (o_valid=1 and i_ready=0), o_out, o_s, o_valid and ptr SHALL hold, and o_ready SHALL be 0000.
REQ-012 The state machine SHALL have two states, EMPTY (o_valid=0) and FULL (o_valid=1):
- EMPTY->FULL on a transfer.
- FULL->FULL on a transfer in a cycle where i_ready=1.
- FULL->EMPTY when i_ready=1 and no transfer.
- FULL holds when i_ready=0.
REQ-013 Latency SHALL be 1 cycle from transfer to o_valid.
REQ-014 Sustained throughput SHALL be 1 transfer per cycle while i_ready=1.
REQ-015 The block SHALL be fair: with all four sources continuously valid and i_ready=1, grants SHALL rotate 0,1,2,3,0,...
REQ-016 A source that is not granted SHALL NOT be consumed; its data and valid are the source's responsibility to hold.
REQ-017 o_out and o_s SHALL change only on a transfer edge or on reset.

Reset
REQ-018 While i_rst=1 at a clock edge, the block SHALL set o_valid<=0, o_out<=0, o_s<=0 and ptr<=0.
REQ-019 o_ready SHALL be 0000 whenever i_rst=1, regardless of i_valid.
REQ-020 Reset SHALL take priority over any simultaneous transfer or hold.
REQ-021 A word held in the output register at reset SHALL be discarded.
REQ-022 The first grant after reset SHALL search from source 0.

Verification
REQ-023 The bench SHALL cover these directed scenarios; unless stated, inputs are i_in0=AAAA_AAAA_AAAA_AAAA, i_in1=BBBB..., i_in2=CCCC..., i_in3=DDDD...:
- Reset: i_rst=1 for 2 cycles with i_valid=1111 and i_ready=1 -> o_valid=0, o_out=0, o_s=0, o_ready=0000.
- Single source: after reset, i_valid=0100 and i_ready=1 -> o_ready=0100 in the same cycle; next cycle o_valid=1, o_out=CCCC..., o_s=2.
- Round robin: after reset, i_valid=1111 and i_ready=1 for 5 cycles -> o_s sequence 0,1,2,3,0 and o_out sequence AAAA..., BBBB..., CCCC..., DDDD..., AAAA....
- Backpressure: with o_valid=1, o_s=1 and i_valid=1111, hold i_ready=0 for 3 cycles -> o_out=BBBB... and o_s=1 stay stable and o_ready=0000; raise i_ready=1 -> o_ready=0100 and next o_s=2.
- Wrap and skip: with ptr=3, i_valid=1001 and i_ready=1 -> grant 3 (o_s=3), then grant 0 (o_s=0, o_out=AAAA...); then i_valid=0000 -> o_valid=0 with o_out held.
- Mid-operation reset: with o_valid=1 and o_s=2, pulse i_rst=1 for 1 cycle -> o_valid=0, o_out=0; then i_valid=1111 -> first o_s=0.
